// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder frame controller: FSM encoding,
// BMU stage qualifier positions and frame timing defaults.
package viterbi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RENEW = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_TB    = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Bit positions inside stage_valid
    localparam int SV_PAIR_0     = 0;
    localparam int SV_PAIR_1     = 1;
    localparam int SV_PAIR_INPUT = 2;

    // BMU/ACS pipeline drain time between the last symbol and traceback
    localparam int VIT_FLUSH_CYC = 3;

    // Shorter frames cannot fill the first two BMU stages plus steady state
    localparam int VIT_MIN_FRAME_LEN = 3;

    // One-hot stage qualifier for a transfer, given its position in the frame
    function automatic logic [2:0] stage_onehot(input logic is_first, input logic is_second);
        if (is_first) begin
            return 3'b001 << SV_PAIR_0;
        end else if (is_second) begin
            return 3'b001 << SV_PAIR_1;
        end else begin
            return 3'b001 << SV_PAIR_INPUT;
        end
    endfunction

endpackage

// File: rtl/vit_sym_counter.sv
// Per-frame symbol counter: latches the frame length on frame start, counts
// accepted bit pairs and flags the transfer that completes the frame.
module vit_sym_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic [LEN_W-1:0] len_in,
    input  logic             inc,
    output logic [LEN_W-1:0] count,
    output logic             last
);

    logic [LEN_W-1:0] len_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            len_q <= '0;
        end else if (frame_start) begin
            count <= '0;
            len_q <= len_in;
        end else if (inc) begin
            count <= count + LEN_W'(1);
        end
    end

    // Compare against len-1 so the count stops exactly at len, even at all-ones
    assign last = inc && (count == len_q - LEN_W'(1));

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Viterbi decoder frame controller: sequences BMU renew, symbol routing into
// the BMU stages, pipeline flush and traceback handshake for one frame.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int LEN_W     = 8,
    parameter int FLUSH_CYC = VIT_FLUSH_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             abort,
    input  logic             sym_valid,
    input  logic [1:0]       sym_data,
    output logic             sym_ready,
    output logic             renew,
    output logic [1:0]       bit_pair_0,
    output logic [1:0]       bit_pair_1,
    output logic [1:0]       bit_pair_input,
    output logic [2:0]       stage_valid,
    output logic             tb_start,
    input  logic             tb_done,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] sym_count
);

    localparam int               FL_W       = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(FLUSH_CYC - 1);
    localparam logic [LEN_W-1:0] MIN_LEN    = LEN_W'(VIT_MIN_FRAME_LEN);

    state_t          state;
    state_t          next_state;
    logic [FL_W-1:0] flush_cnt;

    logic len_ok;
    logic start_ok;
    logic abort_ok;
    logic flush_last;
    logic xfer;
    logic last_sym;
    logic is_first;
    logic is_second;
    logic renew_d;
    logic tb_start_d;
    logic err_d;

    assign len_ok     = (frame_len >= MIN_LEN);
    assign start_ok   = (state == ST_IDLE) && start && len_ok;
    assign abort_ok   = abort && (state inside {ST_RENEW, ST_LOAD, ST_FLUSH, ST_TB});
    assign flush_last = (flush_cnt == FLUSH_LAST);
    assign xfer       = sym_valid && sym_ready;
    assign is_first   = (sym_count == '0);
    assign is_second  = (sym_count == LEN_W'(1));

    vit_sym_counter #(
        .LEN_W (LEN_W)
    ) u_sym_counter (
        .clk         (clk),
        .rst         (rst),
        .frame_start (start_ok),
        .len_in      (frame_len),
        .inc         (xfer),
        .count       (sym_count),
        .last        (last_sym)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort has priority over every forward transition, including flush expiry and tb_done
    always_comb begin
        // NOTE: default assignment first keeps this block latch-free.
        next_state = state;
        case (state)
            ST_IDLE:  if (start_ok) next_state = ST_RENEW;
            ST_RENEW: next_state = abort ? ST_IDLE : ST_LOAD;
            ST_LOAD: begin
                if (abort)         next_state = ST_IDLE;
                else if (last_sym) next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (abort)           next_state = ST_IDLE;
                else if (flush_last) next_state = ST_TB;
            end
            ST_TB: begin
                if (abort)        next_state = ST_IDLE;
                else if (tb_done) next_state = ST_DONE;
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        sym_ready  = (state == ST_LOAD) && !abort;
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        renew_d    = start_ok || abort_ok;
        tb_start_d = (state == ST_FLUSH) && (next_state == ST_TB);
        err_d      = (state == ST_IDLE) && start && !len_ok;
    end

    // Pulses are registered so they appear in the first cycle of the new state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            renew    <= 1'b0;
            tb_start <= 1'b0;
            err      <= 1'b0;
        end else begin
            renew    <= renew_d;
            tb_start <= tb_start_d;
            err      <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if ((state == ST_FLUSH) && (next_state == ST_FLUSH)) begin
            flush_cnt <= flush_cnt + FL_W'(1);
        end else begin
            flush_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: datapath registers are reset too, so the BMU never sees X pairs after rst.
        if (rst) begin
            stage_valid    <= 3'b000;
            bit_pair_0     <= 2'b00;
            bit_pair_1     <= 2'b00;
            bit_pair_input <= 2'b00;
        end else begin
            stage_valid <= xfer ? stage_onehot(is_first, is_second) : 3'b000;
            if (xfer) begin
                if (is_first) begin
                    bit_pair_0 <= sym_data;
                end else if (is_second) begin
                    bit_pair_1 <= sym_data;
                end else begin
                    bit_pair_input <= sym_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the DUT emits one.
module tb_viterbi_frame_ctrl;

    localparam int LEN_W     = 8;
    localparam int FLUSH_CYC = 3;
    localparam int MAX_LEN   = (1 << LEN_W) - 1;

    localparam int MODE_NONE  = 0;
    localparam int MODE_LOAD  = 1;
    localparam int MODE_FLUSH = 2;
    localparam int MODE_TB    = 3;
    localparam int MODE_RST   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] frame_len = '0;
    logic             abort = 1'b0;
    logic             sym_valid = 1'b0;
    logic [1:0]       sym_data = 2'b00;
    logic             tb_done = 1'b0;
    logic             sym_ready;
    logic             renew;
    logic [1:0]       bit_pair_0;
    logic [1:0]       bit_pair_1;
    logic [1:0]       bit_pair_input;
    logic [2:0]       stage_valid;
    logic             tb_start;
    logic             busy;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] sym_count;

    typedef struct {
        int         idx;
        logic [1:0] data;
    } stage_exp_t;

    stage_exp_t stage_q[$];
    int         renew_q[$];
    int         done_q[$];
    int         err_q[$];
    int         tbs_q[$];
    stage_exp_t mon_e;
    logic [1:0] m_bp[3] = '{2'b00, 2'b00, 2'b00};
    int         cyc_no = 0;
    int         last_sv_cyc = 0;
    int         n_vec = 0;
    int         n_mis = 0;

    always #5 clk = ~clk;

    viterbi_frame_ctrl #(
        .LEN_W     (LEN_W),
        .FLUSH_CYC (FLUSH_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .frame_len      (frame_len),
        .abort          (abort),
        .sym_valid      (sym_valid),
        .sym_data       (sym_data),
        .sym_ready      (sym_ready),
        .renew          (renew),
        .bit_pair_0     (bit_pair_0),
        .bit_pair_1     (bit_pair_1),
        .bit_pair_input (bit_pair_input),
        .stage_valid    (stage_valid),
        .tb_start       (tb_start),
        .tb_done        (tb_done),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .sym_count      (sym_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst sym_ready", sym_ready, 0);
        check("rst renew", renew, 0);
        check("rst stage_valid", stage_valid, 0);
        check("rst tb_start", tb_start, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        check("rst bit_pair_0", bit_pair_0, 0);
        check("rst bit_pair_1", bit_pair_1, 0);
        check("rst bit_pair_input", bit_pair_input, 0);
        check("rst sym_count", sym_count, 0);
    endtask

    // Monitor: every DUT event must match the oldest expectation of its kind
    always @(negedge clk) begin
        cyc_no++;
        if (!rst) begin
            if (stage_valid != 3'b000) begin
                if (stage_q.size() == 0) begin
                    check("unexpected stage_valid", 32'(stage_valid), 0);
                end else begin
                    mon_e = stage_q.pop_front();
                    m_bp[mon_e.idx] = mon_e.data;
                    check("stage_valid", 32'(stage_valid), 32'(1) << mon_e.idx);
                    check("bit_pair_0", 32'(bit_pair_0), 32'(m_bp[0]));
                    check("bit_pair_1", 32'(bit_pair_1), 32'(m_bp[1]));
                    check("bit_pair_input", 32'(bit_pair_input), 32'(m_bp[2]));
                    last_sv_cyc = cyc_no;
                end
            end
            if (renew) begin
                if (renew_q.size() == 0) check("unexpected renew", 32'(renew), 0);
                else check("renew sym_count", 32'(sym_count), renew_q.pop_front());
            end
            if (tb_start) begin
                if (tbs_q.size() == 0) check("unexpected tb_start", 32'(tb_start), 0);
                else check("tb_start delay", cyc_no - last_sv_cyc, tbs_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) check("unexpected done", 32'(done), 0);
                else check("done sym_count", 32'(sym_count), done_q.pop_front());
            end
            if (err) begin
                if (err_q.size() == 0) check("unexpected err", 32'(err), 0);
                else check("err busy", 32'(busy), err_q.pop_front());
            end
        end
    end

    task automatic err_frame(input int len);
        start = 1'b1;
        frame_len = LEN_W'(len);
        err_q.push_back(0);
        cyc();
        start = 1'b0;
        check("busy after short start", busy, 0);
        cyc();
        check("busy idle after err", busy, 0);
    endtask

    // One frame: pair k goes to stage min(k,2); mode/pos choose an abort or reset point
    task automatic run_frame(input logic [1:0] syms[$], input int min_gap, input int max_gap,
                             input int mode, input int pos);
        int len;
        len = syms.size();
        start = 1'b1;
        frame_len = LEN_W'(len);
        renew_q.push_back(0);
        cyc();
        start = 1'b0;
        check("busy in RENEW", busy, 1);
        check("sym_ready in RENEW", sym_ready, 0);
        cyc();
        for (int k = 0; k < len; k++) begin
            int gap;
            gap = $urandom_range(max_gap, min_gap);
            for (int g = 0; g < gap; g++) begin
                sym_valid = 1'b0;
                sym_data  = 2'($urandom);
                tb_done   = 1'($urandom);
                start     = 1'($urandom);
                frame_len = LEN_W'($urandom);
                cyc();
                check("sym_count hold in gap", sym_count, k);
            end
            tb_done   = 1'b0;
            start     = 1'b0;
            sym_valid = 1'b1;
            sym_data  = syms[k];
            if (mode == MODE_LOAD && k == pos) begin
                abort = 1'b1;
                @(negedge clk);
                check("sym_ready under abort", sym_ready, 0);
                renew_q.push_back(k);
                cyc();
                abort = 1'b0;
                sym_valid = 1'b0;
                check("busy after LOAD abort", busy, 0);
                cyc();
                return;
            end
            @(negedge clk);
            check("sym_ready in LOAD", sym_ready, 1);
            stage_q.push_back('{idx: (k < 2) ? k : 2, data: syms[k]});
            cyc();
            sym_valid = 1'b0;
            check("sym_count after transfer", sym_count, k + 1);
        end
        check("sym_ready in FLUSH", sym_ready, 0);
        if (mode == MODE_FLUSH) begin
            repeat (pos) cyc();
            abort = 1'b1;
            renew_q.push_back(len);
            cyc();
            abort = 1'b0;
            check("busy after FLUSH abort", busy, 0);
            cyc();
            return;
        end
        tbs_q.push_back(FLUSH_CYC);
        for (int i = 0; i < FLUSH_CYC; i++) begin
            tb_done = 1'($urandom);
            cyc();
        end
        tb_done = 1'b0;
        check("busy in TB", busy, 1);
        if (mode == MODE_TB) begin
            repeat (pos) cyc();
            abort = 1'b1;
            tb_done = 1'b1;
            renew_q.push_back(len);
            cyc();
            abort = 1'b0;
            tb_done = 1'b0;
            check("busy after TB abort", busy, 0);
            cyc();
            return;
        end
        if (mode == MODE_RST) begin
            cyc();
            #2;
            rst = 1'b1;
            m_bp = '{2'b00, 2'b00, 2'b00};
            #1;
            check_reset_outputs();
            @(posedge clk);
            #1;
            rst = 1'b0;
            tb_done = 1'b1;
            cyc();
            tb_done = 1'b0;
            check("busy after rst", busy, 0);
            cyc();
            return;
        end
        repeat ($urandom_range(3, 0)) begin
            start = 1'($urandom);
            frame_len = LEN_W'($urandom);
            cyc();
        end
        start = 1'b0;
        tb_done = 1'b1;
        done_q.push_back(len);
        cyc();
        tb_done = 1'b0;
        check("busy in DONE", busy, 1);
        abort = 1'b1;
        cyc();
        check("busy after DONE", busy, 0);
        check("sym_count retained", sym_count, len);
        cyc();
        abort = 1'b0;
        cyc();
        check("sym_count retained idle", sym_count, len);
    endtask

    initial begin
        logic [1:0] pat[$];
        int len;
        int mode;
        int pos;

        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();

        pat = {2'b11, 2'b01, 2'b10, 2'b00};
        run_frame(pat, 0, 0, MODE_NONE, 0);

        err_frame(2);
        err_frame(0);
        err_frame(1);

        pat = {2'b10, 2'b11, 2'b01, 2'b00, 2'b11};
        run_frame(pat, 2, 2, MODE_NONE, 0);

        pat = {2'b01, 2'b10, 2'b11, 2'b00};
        run_frame(pat, 0, 0, MODE_LOAD, 2);

        for (int f = 0; f < 30; f++) begin
            len  = $urandom_range(10, 3);
            mode = $urandom_range(MODE_TB, MODE_NONE);
            pat.delete();
            for (int i = 0; i < len; i++) pat.push_back(2'($urandom));
            case (mode)
                MODE_LOAD:  pos = $urandom_range(len - 1, 0);
                MODE_FLUSH: pos = $urandom_range(FLUSH_CYC - 1, 0);
                default:    pos = $urandom_range(2, 0);
            endcase
            run_frame(pat, 0, $urandom_range(2, 0), mode, pos);
        end

        pat = {2'b11, 2'b10, 2'b01, 2'b11, 2'b10};
        run_frame(pat, 0, 1, MODE_RST, 0);

        pat.delete();
        for (int i = 0; i < MAX_LEN; i++) pat.push_back(2'($urandom));
        run_frame(pat, 0, 0, MODE_NONE, 0);

        repeat (4) cyc();
        check("stage queue drained", stage_q.size(), 0);
        check("renew queue drained", renew_q.size(), 0);
        check("tb_start queue drained", tbs_q.size(), 0);
        check("done queue drained", done_q.size(), 0);
        check("err queue drained", err_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
